// File: rtl/led_seq_pkg.sv
// Mode/state codes and pattern tables shared by the RGB LED sequencer.
package led_seq_pkg;

    typedef logic [1:0] led_mode_t;
    typedef logic [1:0] led_state_t;

    localparam led_mode_t MODE_OFF   = 2'd0;
    localparam led_mode_t MODE_CYCLE = 2'd1;
    localparam led_mode_t MODE_BLINK = 2'd2;
    localparam led_mode_t MODE_SOLID = 2'd3;

    localparam led_state_t ST_IDLE  = 2'd0;
    localparam led_state_t ST_BLANK = 2'd1;
    localparam led_state_t ST_RUN   = 2'd2;

    function automatic logic [2:0] step_count(input led_mode_t mode);
        case (mode)
            MODE_CYCLE: step_count = 3'd4;
            MODE_BLINK: step_count = 3'd2;
            default:    step_count = 3'd1;
        endcase
    endfunction

    function automatic logic [1:0] next_step(input led_mode_t mode, input logic [1:0] step);
        logic [2:0] inc;
        inc       = {1'b0, step} + 3'd1;
        next_step = (inc >= step_count(mode)) ? 2'd0 : inc[1:0];
    endfunction

    // Returns {R,G,B} with 1 meaning the channel is lit.
    function automatic logic [2:0] colour(input led_mode_t mode, input logic [1:0] step);
        colour = 3'b000;
        case (mode)
            MODE_CYCLE: begin
                case (step)
                    2'd0:    colour = 3'b100;
                    2'd1:    colour = 3'b010;
                    2'd2:    colour = 3'b001;
                    default: colour = 3'b111;
                endcase
            end
            MODE_BLINK: colour = (step == 2'd0) ? 3'b100 : 3'b000;
            MODE_SOLID: colour = 3'b111;
            default:    colour = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..DIV-1 while enabled and pulses tick on the last count.
module led_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en & (cnt == CW'(DIV - 1));

    // A disabled prescaler sits at zero so a resumed pattern gets a full dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED pattern scheduler with valid/ready mode requests and timed steps.
// Optional brightness PWM is built only when LED_PWM_DIM_EN is defined.
module rgb_led_sequencer #(
    parameter int CLK_HZ   = 12_000_000,
    parameter int STEP_MS  = 250,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode_req_valid,
    input  logic [1:0]          mode_req,
    output logic                mode_req_ready,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                led_red,
    output logic                led_green,
    output logic                led_blue,
    output logic [1:0]          step_idx,
    output logic                busy
);

    import led_seq_pkg::*;

    localparam int TICK_DIV = CLK_HZ / 1000 * STEP_MS;

    led_state_t state;
    led_mode_t  cur_mode;
    logic       rst_done;
    logic       tick;
    logic       accept;
    logic [2:0] colour_bits;
    logic [2:0] lit;

    // Ready stays low through the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    assign mode_req_ready = rst_done & enable & (state != ST_BLANK);
    assign accept         = mode_req_valid & mode_req_ready;
    assign busy           = (state != ST_IDLE);

    led_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .clear (accept),
        .tick  (tick)
    );

    // An accepted request outranks a coincident tick, so the step never advances then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_mode <= MODE_OFF;
            step_idx <= 2'd0;
        end else if (!enable) begin
            state <= ST_IDLE;
        end else if (accept) begin
            cur_mode <= mode_req;
            step_idx <= 2'd0;
            state    <= ST_BLANK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cur_mode != MODE_OFF) state <= ST_RUN;
                end
                ST_BLANK: begin
                    if (tick) state <= (cur_mode != MODE_OFF) ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (tick) step_idx <= next_step(cur_mode, step_idx);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        colour_bits = 3'b000;
        if (state == ST_RUN && enable) colour_bits = colour(cur_mode, step_idx);
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    assign lit = colour_bits & {3{pwm_cnt < brightness}};
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign lit               = colour_bits;
`endif

    // Pins are active-low and registered to keep them glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {led_red, led_green, led_blue} <= 3'b111;
        end else begin
            {led_red, led_green, led_blue} <= ~lit;
        end
    end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Scoreboard bench for rgb_led_sequencer with a cycle-level reference model.
module tb_rgb_led_sequencer;

    localparam int CLK_HZ   = 1000;
    localparam int STEP_MS  = 4;
    localparam int PWM_BITS = 8;
    localparam int TICK_DIV = 4;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_CYCLE = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_SOLID = 2'd3;

    localparam int S_IDLE  = 0;
    localparam int S_BLANK = 1;
    localparam int S_RUN   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable;
    logic       mode_req_valid;
    logic [1:0] mode_req;
    logic       mode_req_ready;
    logic [7:0] brightness;
    logic       led_red;
    logic       led_green;
    logic       led_blue;
    logic [1:0] step_idx;
    logic       busy;

    typedef struct packed {
        logic [2:0] pins;
        logic [1:0] step;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_state;
    int m_mode;
    int m_step;
    int m_cnt;
    int m_pwm;
    logic m_rst_done;
    logic [7:0] br_cur = 8'd0;

    rgb_led_sequencer #(
        .CLK_HZ   (CLK_HZ),
        .STEP_MS  (STEP_MS),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .mode_req_valid (mode_req_valid),
        .mode_req       (mode_req),
        .mode_req_ready (mode_req_ready),
        .brightness     (brightness),
        .led_red        (led_red),
        .led_green      (led_green),
        .led_blue       (led_blue),
        .step_idx       (step_idx),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cyc %0d: got 0x%0h want 0x%0h", tag, cyc, actual, expected);
        end
    endtask

    // Lit colour {R,G,B} written out from the pattern description.
    function automatic logic [2:0] exp_colour(input int mode, input int step);
        case (mode * 4 + step)
            4:       exp_colour = 3'b100;
            5:       exp_colour = 3'b010;
            6:       exp_colour = 3'b001;
            7:       exp_colour = 3'b111;
            8:       exp_colour = 3'b100;
            12:      exp_colour = 3'b111;
            default: exp_colour = 3'b000;
        endcase
    endfunction

    function automatic int exp_next_step(input int mode, input int step);
        case (mode)
            1:       exp_next_step = (step + 1) % 4;
            2:       exp_next_step = (step + 1) % 2;
            default: exp_next_step = 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state    = S_IDLE;
        m_mode     = 0;
        m_step     = 0;
        m_cnt      = 0;
        m_pwm      = 0;
        m_rst_done = 1'b0;
        exp_q.delete();
    endtask

    // Drives one cycle of inputs, predicts the post-edge outputs, then compares.
    task automatic applyStimulus(input logic en, input logic vld, input logic [1:0] req, input logic [7:0] br);
        logic       m_ready;
        logic       m_tick;
        logic       m_acc;
        logic [2:0] m_lit;
        exp_t       e;
        exp_t       got;
        enable         = en;
        mode_req_valid = vld;
        mode_req       = req;
        brightness     = br;
        m_ready = m_rst_done && en && (m_state != S_BLANK);
        #1;
        checkOutput("ready", {31'd0, mode_req_ready}, {31'd0, m_ready});
        m_tick = en && (m_cnt == TICK_DIV - 1);
        m_acc  = vld && m_ready;
        m_lit  = (m_state == S_RUN && en) ? exp_colour(m_mode, m_step) : 3'b000;
`ifdef LED_PWM_DIM_EN
        if (!(m_pwm < int'(br))) m_lit = 3'b000;
`endif
        m_pwm = (m_pwm + 1) % 256;
        if (!en) begin
            m_state = S_IDLE;
            m_cnt   = 0;
        end else if (m_acc) begin
            m_mode  = int'(req);
            m_step  = 0;
            m_cnt   = 0;
            m_state = S_BLANK;
        end else begin
            m_cnt = m_tick ? 0 : m_cnt + 1;
            if (m_state == S_IDLE && m_mode != 0) m_state = S_RUN;
            else if (m_state == S_BLANK && m_tick) m_state = (m_mode != 0) ? S_RUN : S_IDLE;
            else if (m_state == S_RUN && m_tick) m_step = exp_next_step(m_mode, m_step);
        end
        m_rst_done = 1'b1;
        e.pins = ~m_lit;
        e.step = 2'(m_step);
        e.busy = (m_state != S_IDLE);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        got = {led_red, led_green, led_blue, step_idx, busy};
        if (exp_q.size() == 0) begin
            checkOutput("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("outs", {26'd0, got}, {26'd0, e});
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, M_OFF, br_cur);
    endtask

    task automatic check_pins(input string tag, input logic [2:0] expected);
`ifndef LED_PWM_DIM_EN
        checkOutput(tag, {29'd0, led_red, led_green, led_blue}, {29'd0, expected});
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_pins", {29'd0, led_red, led_green, led_blue}, 32'd7);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_step", {30'd0, step_idx}, 32'd0);
        checkOutput("rst_ready", {31'd0, mode_req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        int low_r;
        int low_g;
        int low_b;
        enable         = 1'b0;
        mode_req_valid = 1'b0;
        mode_req       = M_OFF;
        brightness     = 8'd0;
        $display("[TB] rgb_led_sequencer bench start");

        do_reset();
        run_cycles(1);
        checkOutput("ready_after_release", {31'd0, mode_req_ready}, 32'd1);

        // Full CYCLE pattern with wrap.
        applyStimulus(1'b1, 1'b1, M_CYCLE, br_cur);
        run_cycles(3);
        check_pins("cycle_blank", 3'b111);
        run_cycles(2);
        check_pins("cycle_red", 3'b011);
        run_cycles(4);
        check_pins("cycle_green", 3'b101);
        run_cycles(4);
        check_pins("cycle_blue", 3'b110);
        run_cycles(4);
        check_pins("cycle_white", 3'b000);
        checkOutput("cycle_step3", {30'd0, step_idx}, 32'd3);
        run_cycles(4);
        checkOutput("cycle_wrap", {30'd0, step_idx}, 32'd0);
        check_pins("cycle_red_again", 3'b011);

        // Accept collides with tick; held valid waits out BLANK.
        guard = 0;
        while (!(m_state == S_RUN && m_cnt == TICK_DIV - 1) && guard < 32) begin
            run_cycles(1);
            guard++;
        end
        checkOutput("wait_tick", {31'd0, guard < 32}, 32'd1);
        applyStimulus(1'b1, 1'b1, M_BLINK, br_cur);
        checkOutput("collide_step", {30'd0, step_idx}, 32'd0);
        checkOutput("collide_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("blank_ready", {31'd0, mode_req_ready}, 32'd0);
            applyStimulus(1'b1, 1'b1, M_SOLID, br_cur);
        end
        checkOutput("run_ready", {31'd0, mode_req_ready}, 32'd1);
        applyStimulus(1'b1, 1'b1, M_SOLID, br_cur);
        checkOutput("solid_accepted", {31'd0, mode_req_ready}, 32'd0);
        run_cycles(5);
        check_pins("solid_white", 3'b000);

        // Disable mid-pattern and resume on the held step.
        applyStimulus(1'b1, 1'b1, M_CYCLE, br_cur);
        guard = 0;
        while (!(m_state == S_RUN && m_step == 2) && guard < 40) begin
            run_cycles(1);
            guard++;
        end
        checkOutput("wait_step2", {31'd0, guard < 40}, 32'd1);
        applyStimulus(1'b0, 1'b0, M_OFF, br_cur);
        checkOutput("dis_pins", {29'd0, led_red, led_green, led_blue}, 32'd7);
        checkOutput("dis_busy", {31'd0, busy}, 32'd0);
        checkOutput("dis_ready", {31'd0, mode_req_ready}, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, M_OFF, br_cur);
        checkOutput("dis_step_held", {30'd0, step_idx}, 32'd2);
        run_cycles(1);
        checkOutput("resume_busy", {31'd0, busy}, 32'd1);
        run_cycles(1);
        check_pins("resume_blue", 3'b110);

        // OFF request drains through BLANK back to IDLE.
        applyStimulus(1'b1, 1'b1, M_OFF, br_cur);
        run_cycles(3);
        checkOutput("off_blank_busy", {31'd0, busy}, 32'd1);
        run_cycles(1);
        checkOutput("off_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("off_pins", {29'd0, led_red, led_green, led_blue}, 32'd7);

        // Reset in the middle of a pattern.
        applyStimulus(1'b1, 1'b1, M_CYCLE, br_cur);
        run_cycles(10);
        do_reset();
        run_cycles(2);
        applyStimulus(1'b1, 1'b1, M_CYCLE, br_cur);
        run_cycles(5);
        checkOutput("post_rst_step", {30'd0, step_idx}, 32'd0);
        check_pins("post_rst_red", 3'b011);

`ifdef LED_PWM_DIM_EN
        br_cur = 8'd64;
        applyStimulus(1'b1, 1'b1, M_SOLID, br_cur);
        run_cycles(8);
        low_r = 0; low_g = 0; low_b = 0;
        for (int i = 0; i < 256; i++) begin
            run_cycles(1);
            if (!led_red)   low_r++;
            if (!led_green) low_g++;
            if (!led_blue)  low_b++;
        end
        checkOutput("pwm64_red", low_r, 32'd64);
        checkOutput("pwm64_green", low_g, 32'd64);
        checkOutput("pwm64_blue", low_b, 32'd64);
        br_cur = 8'd0;
        run_cycles(2);
        low_r = 0; low_g = 0; low_b = 0;
        for (int i = 0; i < 256; i++) begin
            run_cycles(1);
            if (!led_red)   low_r++;
            if (!led_green) low_g++;
            if (!led_blue)  low_b++;
        end
        checkOutput("pwm0_lows", low_r + low_g + low_b, 32'd0);
`else
        low_r = 0; low_g = 0; low_b = 0;
        applyStimulus(1'b1, 1'b1, M_SOLID, 8'd0);
        run_cycles(6);
        check_pins("bright_ignored", 3'b000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
